// File: rtl/multiplier_control.sv
// Sequencing FSM for the 8-bit signed shift-add multiplier: turns the Run and
// ClearA_LoadB switch levels into single-cycle datapath strobes.
module multiplier_control #(
   parameter int N = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 run_i,
   input  logic                 clear_a_load_b_i,
   input  logic                 m_i,
   output logic                 clr_xa_o,
   output logic                 ld_b_o,
   output logic                 add_o,
   output logic                 sub_o,
   output logic                 shift_en_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [$clog2(N)-1:0] iter_o
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADD,
      S_SHIFT,
      S_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] iter_q, iter_d;
   logic          run_q;
   logic          armed_q;
   logic          start_clr_q;
   logic          shift_q;
   logic          busy_q;
   logic          done_q;
   logic          start_req;
   logic          idle_load;

   // armed_q blocks a start until Run has been seen high after reset, so a
   // Run held low through reset cannot masquerade as a falling edge.
   assign start_req = armed_q && run_q && !run_i;

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_req) state_d = S_START;
         end
         S_START: begin
            iter_d  = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (iter_q == LAST) begin
               state_d = S_HOLD;
            end else begin
               iter_d  = iter_q + IW'(1);
               state_d = S_ADD;
            end
         end
         S_HOLD: begin
            if (run_i) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         iter_q      <= '0;
         run_q       <= 1'b1;
         armed_q     <= 1'b0;
         start_clr_q <= 1'b0;
         shift_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         iter_q      <= iter_d;
         run_q       <= run_i;
         armed_q     <= armed_q | run_i;
         start_clr_q <= (state_d == S_START);
         shift_q     <= (state_d == S_SHIFT);
         busy_q      <= (state_d == S_START) || (state_d == S_ADD) || (state_d == S_SHIFT);
         done_q      <= (state_q == S_SHIFT) && (state_d == S_HOLD);
      end
   end

   // The IDLE load/clear follows the switch level directly; a coinciding start wins.
   assign idle_load = (state_q == S_IDLE) && !clear_a_load_b_i && !start_req && !rst_i;

   // Add/Sub must see M live in ADD: B's LSB only settles after the SHIFT edge.
   assign add_o      = (state_q == S_ADD) && m_i && (iter_q != LAST);
   assign sub_o      = (state_q == S_ADD) && m_i && (iter_q == LAST);
   assign clr_xa_o   = start_clr_q | idle_load;
   assign ld_b_o     = idle_load;
   assign shift_en_o = shift_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign iter_o     = iter_q;

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: drives a small X:A:B datapath model from the
// strobes and scores each finished multiply against the signed product.
module tb_multiplier_control;

   localparam int N  = 8;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b1;
   logic          cl  = 1'b1;
   logic          m;
   logic          clr_xa, ld_b, add, sub, shift_en, busy, done;
   logic [IW-1:0] iter;

   logic [7:0] sw    = 8'h00;
   logic       x_reg = 1'b0;
   logic [7:0] a_reg = 8'h00;
   logic [7:0] b_reg = 8'h00;
   logic [7:0] b_ref = 8'h00;

   typedef struct {
      logic [15:0] ab;
      int          nadd;
      int          nsub;
      int          done_cyc;
   } exp_t;
   exp_t sbq[$];

   int total = 0, bad = 0;
   int cyc = 0;
   int add_cnt = 0, sub_cnt = 0, shift_cnt = 0, busy_cnt = 0, done_cnt = 0;

   assign m = b_reg[0];

   multiplier_control #(.N(N)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .run_i           (run),
      .clear_a_load_b_i(cl),
      .m_i             (m),
      .clr_xa_o        (clr_xa),
      .ld_b_o          (ld_b),
      .add_o           (add),
      .sub_o           (sub),
      .shift_en_o      (shift_en),
      .busy_o          (busy),
      .done_o          (done),
      .iter_o          (iter)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: datapath model plus scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      logic [8:0] sum;
      exp_t       e;
      if (rst) begin
         add_cnt = 0; sub_cnt = 0; shift_cnt = 0; busy_cnt = 0;
      end else begin
         if (busy) begin
            chk("ld_b_while_busy", ld_b, 0);
            chk("clr_xa_while_busy", clr_xa, busy_cnt == 0);
            busy_cnt++;
         end
         chk("add_sub_exclusive", add & sub, 0);
         if (add) add_cnt++;
         if (sub) sub_cnt++;
         if (shift_en) begin
            chk("iter_at_shift", iter, shift_cnt);
            shift_cnt++;
         end
         if (clr_xa) begin x_reg = 1'b0; a_reg = 8'h00; end
         if (ld_b) b_reg = sw;
         if (add) begin
            sum = {a_reg[7], a_reg} + {sw[7], sw};
            {x_reg, a_reg} = sum;
         end
         if (sub) begin
            sum = {a_reg[7], a_reg} - {sw[7], sw};
            {x_reg, a_reg} = sum;
         end
         if (shift_en) {x_reg, a_reg, b_reg} = {x_reg, x_reg, a_reg, b_reg[7:1]};
         if (done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: got done=1 want no pending operation (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               chk("product_ab", {a_reg, b_reg}, e.ab);
               chk("add_pulses", add_cnt, e.nadd);
               chk("sub_pulses", sub_cnt, e.nsub);
               chk("shift_pulses", shift_cnt, N);
               chk("busy_cycles", busy_cnt, 2 * N + 1);
               chk("done_cycle", cyc, e.done_cyc);
               $display("op done: ab=%04h add=%0d sub=%0d shift=%0d busy=%0d", {a_reg, b_reg},
                        add_cnt, sub_cnt, shift_cnt, busy_cnt);
            end
            add_cnt = 0; sub_cnt = 0; shift_cnt = 0; busy_cnt = 0;
         end
      end
   end

   task automatic load(input logic [7:0] s, input int ncyc);
      @(posedge clk); #1;
      sw = s;
      cl = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         #1;
         chk("idle_ld_b", ld_b, 1);
         chk("idle_clr_xa", clr_xa, 1);
         @(posedge clk); #1;
      end
      cl = 1'b1;
      b_ref = s;
      $display("load B=%02h for %0d cycles", s, ncyc);
   endtask

   task automatic run_op(input logic [7:0] s, input int hold, input bit coincide, input bit clr_hold);
      exp_t e;
      int   sp, bp, d0, w;
      logic [15:0] p;
      @(posedge clk); #1;
      sw = s;
      sp = int'($signed(s));
      bp = int'($signed(b_ref));
      p  = 16'(sp * bp);
      e.ab       = p;
      e.nadd     = $countones(b_ref[6:0]);
      e.nsub     = int'(b_ref[7]);
      e.done_cyc = cyc + 2 * N + 2;
      sbq.push_back(e);
      $display("run S=%02h B=%02h expect ab=%04h hold=%0d coincide=%0d clr_hold=%0d",
               s, b_ref, p, hold, coincide, clr_hold);
      b_ref = p[7:0];
      run = 1'b0;
      if (coincide || clr_hold) cl = 1'b0;
      #1;
      if (!cl) chk("start_wins_ld_b", ld_b, 0);
      d0 = done_cnt;
      w  = 0;
      while (done_cnt == d0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      if (done_cnt == d0) begin
         total++; bad++;
         $display("FAIL done_timeout: got no done want done within 100 cycles");
      end
      if (!clr_hold) cl = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk("hold_ld_b", ld_b, 0);
         chk("hold_busy", busy, 0);
      end
      @(posedge clk); #1;
      cl  = 1'b1;
      run = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int w;
      // Reset state, with ClearA_LoadB low to prove the IDLE terms are masked.
      cl = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_clr_xa", clr_xa, 0);
      chk("rst_ld_b", ld_b, 0);
      chk("rst_add", add, 0);
      chk("rst_sub", sub, 0);
      chk("rst_shift", shift_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_iter", iter, 0);
      cl = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      load(8'd59, 1);
      run_op(8'd7, 2, 0, 0);
      load(8'hC5, 1);
      run_op(8'd7, 2, 0, 0);
      load(8'h3B, 2);
      run_op(8'hF9, 3, 0, 1);

      load(8'hFE, 1);
      for (int i = 0; i < 4; i++) run_op(8'hFE, 40, 0, 0);

      load(8'h6D, 3);
      run_op(8'h93, 1, 1, 1);

      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 2) == 0) load(8'($urandom), $urandom_range(1, 3));
         run_op(8'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Abort at Iter=4 with an asynchronous mid-cycle reset.
      load(8'hFF, 1);
      @(posedge clk); #1;
      sw  = 8'h55;
      run = 1'b0;
      w   = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(busy && iter == IW'(4)) && w < 40);
      chk("abort_reached_iter4", iter, 4);
      #2;
      rst = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_shift", shift_en, 0);
      chk("async_add_sub", {add, sub}, 0);
      chk("async_done", done, 0);
      chk("async_clr_ld", {clr_xa, ld_b}, 0);
      chk("async_iter", iter, 0);
      $display("abort at iter 4 by async reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("no_start_run_low_after_reset", busy, 0);
      end
      @(posedge clk); #1;
      run = 1'b1;
      repeat (2) @(posedge clk);
      load(8'h2C, 1);
      run_op(8'hE3, 2, 0, 0);

      repeat (5) @(posedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiplier_control.md
# multiplier_control

Control unit for the 8-bit signed shift-add multiplier. It turns the debounced, active-low Run and ClearA_LoadB switch inputs into single-cycle datapath strobes. These strobes clear A and X, load B, add or subtract the switch operand into A, and shift X:A:B. The sign-correcting subtract is issued on the final iteration. The block sits between the switch/button front end and the register/adder datapath, and holds no data itself.

## Interface
- N, 8, operand width = number of add/shift iterations (N >= 2)
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; returns the block to IDLE
- Run  in  1  active-low start request (already debounced, level)
- ClearA_LoadB  in  1  active-low; in IDLE requests clear of X/A and load of B from switches
- M  in  1  current LSB of register B (multiplier bit under test)
- Clr_XA  out  1  clear X and A this cycle
- Ld_B  out  1  load B from switches this cycle
- Add  out  1  A <= A + S (sign-extended into X) this cycle
- Sub  out  1  A <= A - S (sign-extended into X) this cycle
- Shift_En  out  1  arithmetic right shift of X:A:B this cycle
- Busy  out  1  high from START through the last SHIFT
- Done  out  1  one-cycle pulse on entry to HOLD
- Iter  out  clog2(N)  current iteration index, 0..N-1

## Operation
- States: IDLE, START, ADD, SHIFT, HOLD.
- The Run edge detector registers Run into run_q; reset value of run_q is 1.
- A start condition is run_q==1 && Run==0 (falling edge). Holding Run low does not retrigger.
- IDLE
  - Ld_B = Clr_XA = ~ClearA_LoadB (combinational, same cycle).
  - On a start condition -> START.
  - If a start and ClearA_LoadB low coincide, start wins; Ld_B/Clr_XA are suppressed that cycle.
- START: Clr_XA=1 for one cycle; Iter <= 0; -> ADD.
  - Clearing only A and X keeps B, so successive Runs chain-multiply the previous low byte by the new S.
- ADD: Add = M && (Iter != N-1); Sub = M && (Iter == N-1); -> SHIFT. Add and Sub are never both high.
- SHIFT: Shift_En=1.
  - If Iter==N-1, -> HOLD, Done pulses.
  - Otherwise Iter <= Iter+1 and -> ADD.
- HOLD: waits for Run==1, then -> IDLE.
  - ClearA_LoadB is ignored in HOLD, START, ADD and SHIFT.
- Busy = state in {START, ADD, SHIFT}.

## Timing
- Reset asserted: state=IDLE, Iter=0, run_q=1. All outputs are forced to 0 while Reset is high, including the IDLE combinational terms. Reset value of every output is 0.
- Reset mid-operation: abort immediately. No further Add/Sub/Shift_En pulses and no Done. After release, the block sits in IDLE; if Run is still low, no start occurs until Run goes high then low.
- Latency: a Run falling edge sampled at edge k gives START in cycle k+1. ADD/SHIFT pairs occupy cycles k+2..k+2N+1. HOLD and Done occur in cycle k+2N+2.
- For N=8: 17 busy cycles, 8 Shift_En pulses, Add+Sub pulses = number of 1 bits presented on M, at most one Sub.
- M is sampled only in ADD. The datapath must update B's LSB by the SHIFT edge.
- All strobes are single-cycle except Ld_B/Clr_XA in IDLE, which follow ClearA_LoadB level.

## Test plan
- Reset with Run=1, ClearA_LoadB=1 -> all outputs 0, Busy=0, Iter=0; asserting Reset asynchronously mid-cycle clears outputs without waiting for Clk.
- With a bench datapath model: load S=7, then S=59, pulse Run low -> Add pulses 5, Sub 0, Shift_En 8, Done once; A:B=0x019D.
- Load S=7, S=0xC5 (-59), run -> Add 3, Sub 1 (final iteration), A:B=0xFE63. Repeat with S=0xF9 (-7), S=0x3B (59) -> A:B=0xFE63.
- Load S=0xFE and run four times with S=0xFE (chained -2^5) -> A:B=0xFFE0; Run held low 40 cycles after each start gives exactly one operation per falling edge.
- ClearA_LoadB low during ADD/SHIFT/HOLD -> no Ld_B/Clr_XA pulses. ClearA_LoadB low in IDLE -> Ld_B=Clr_XA=1 every cycle it is low. Run falling together with ClearA_LoadB low -> START taken, no Ld_B.
- Reset pulse at Iter=4 -> IDLE next, no Done. Subsequent Run falling edge -> full 17-cycle operation with Iter restarting at 0.
